// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
//   Inhibits the bus, issues request-to-send, then shifts out
//   {stop, odd parity, byte} on the device-generated clock and samples the ack.
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   start, tx_byte    one-cycle request with the byte to send (ignored while busy)
//   ps2_clk_in/_data  raw open-drain lines (asynchronous)
//   ps2_clk_oe/_data_oe  1 = pull the line low, 0 = release
//   busy, done        transaction in flight / one-cycle end pulse
//   ack_ok, error     result, valid from done until the next accepted start
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       error
);
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_DATA, S_PARITY, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t        state;
  logic          clk_s1, clk_s2, clk_prev;
  logic          data_s1, data_s2;
  logic          fall;
  logic          to_active, to_expire;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] to_cnt;
  logic [8:0]    shreg;   // {parity, byte}, bit 0 is the next bit on the wire
  logic [2:0]    bitcnt;

  // Synchronizers reset to 1 (idle bus level) so reset never fakes a falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk_in;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= ps2_data_in;
      data_s2  <= data_s1;
    end
  end

  assign fall      = clk_prev & ~clk_s2;
  assign to_active = state inside {S_RTS, S_DATA, S_PARITY, S_ACK, S_WAIT_IDLE};
  // A fall in the expiry cycle clears the counter instead of timing out.
  assign to_expire = to_active && !fall && (to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ack_ok      <= 1'b0;
      error       <= 1'b0;
      inh_cnt     <= '0;
      to_cnt      <= '0;
      shreg       <= '0;
      bitcnt      <= '0;
    end else begin
      done <= 1'b0;

      // Held at zero until RTS so it starts clean on RTS entry; saturates.
      if (!to_active || fall) to_cnt <= '0;
      else if (to_cnt != TO_LAST) to_cnt <= to_cnt + 1'b1;

      if (to_expire) begin
        error       <= 1'b1;
        ack_ok      <= 1'b0;
        ps2_clk_oe  <= 1'b0;
        ps2_data_oe <= 1'b0;
        busy        <= 1'b0;
        done        <= 1'b1;
        state       <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: if (start) begin
            shreg       <= {~^tx_byte, tx_byte};
            ack_ok      <= 1'b0;
            error       <= 1'b0;
            busy        <= 1'b1;
            ps2_clk_oe  <= 1'b1;
            ps2_data_oe <= 1'b0;
            inh_cnt     <= '0;
            state       <= S_INHIBIT;
          end
          S_INHIBIT: begin
            if (inh_cnt == INH_LAST) begin
              ps2_clk_oe  <= 1'b0;
              ps2_data_oe <= 1'b1;   // start bit
              state       <= S_RTS;
            end else begin
              inh_cnt <= inh_cnt + 1'b1;
            end
          end
          S_RTS: if (fall) begin
            ps2_data_oe <= ~shreg[0];
            shreg       <= shreg >> 1;
            bitcnt      <= '0;
            state       <= S_DATA;
          end
          // After bit7 has gone out, shreg[0] holds parity for the next fall.
          S_DATA: if (fall) begin
            ps2_data_oe <= ~shreg[0];
            shreg       <= shreg >> 1;
            if (bitcnt == 3'd7) state <= S_PARITY;
            else                bitcnt <= bitcnt + 1'b1;
          end
          S_PARITY: if (fall) begin
            ps2_data_oe <= 1'b0;     // stop bit
            state       <= S_ACK;
          end
          S_ACK: if (fall) begin
            if (data_s2) error  <= 1'b1;
            else         ack_ok <= 1'b1;
            state <= S_WAIT_IDLE;
          end
          S_WAIT_IDLE: if (clk_s2 && data_s2) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule
